dot_product_sequencer: RTL and testbench
========================================

# dot_product_sequencer

Control stage upstream of the 4-bit serial-parallel multiplier. It accepts 4-bit operand pairs over a valid/ready handshake and launches one multiplication per pair by pulsing the multiplier's reset. It waits for the multiplier's finish flag, then adds each 8-bit product into an accumulator. After `N_TERMS` products it presents the dot-product result on a valid/ready output port.

## Interface
- `N_TERMS`, default 4: products per result; must be ≥ 1.
- `ACC_W`, default 12: accumulator/result width; must be ≥ 8.
- `clk`  in  1  clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  sequencer can accept a pair.
- `in_a`  in  4  multiplier operand (drives multiplier `A`).
- `in_b`  in  4  multiplicand operand (drives multiplier `B`).
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes result.
- `res_data`  out  ACC_W  accumulated sum.
- `res_ovf`  out  1  sticky: an accumulation carried out of ACC_W bits.
- `mul_reset`  out  1  to multiplier `reset`; restarts it.
- `mul_a`, `mul_b`  out  4 each  to multiplier `A`, `B`.
- `mul_out`  in  8  from multiplier `out`.
- `mul_finish`  in  1  from multiplier `finish`.

## Operation
- States: IDLE, START, WAIT, CAPT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, latch `in_a`/`in_b` into `mul_a`/`mul_b` and go to START.
- START: `mul_reset`=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - `mul_reset`=0.
  - On the first cycle with `mul_finish`=1, go to CAPT.
  - The multiplier updates `out` on the edge that ends that cycle, so `mul_out` is not sampled in WAIT.
- CAPT:
  - Update `acc <= acc + mul_out`, zero-extended to ACC_W, wrapping modulo 2^ACC_W.
  - Set `res_ovf` if that add carries out of ACC_W bits.
  - Increment the term counter.
  - If the counter was `N_TERMS-1`, go to DONE; otherwise go to IDLE.
- DONE:
  - `res_valid`=1, `in_ready`=0.
  - `res_data` and `res_ovf` stay stable until the handshake.
  - On `res_ready`, clear acc, counter and `res_ovf`, and go to IDLE.
- `mul_reset`=1 in IDLE, START and DONE; 0 in WAIT and CAPT. This keeps the multiplier parked in reset between operations.
- `mul_a`/`mul_b` change only on accept in IDLE; they are held from START through CAPT.
- `res_data` is a direct view of the accumulator.
- Reset values:
  - state IDLE, acc 0, counter 0.
  - `res_valid` 0, `res_data` 0, `res_ovf` 0.
  - `in_ready` 1, `mul_reset` 1, `mul_a` 0, `mul_b` 0.
- Reset mid-operation (any state):
  - Partial sum and count are discarded and the block returns to IDLE next cycle.
  - A held result in DONE is lost.
- Any `mul_finish` in IDLE, START, CAPT or DONE is ignored. This includes a stale finish from the previous operation during START.
- `in_valid` while `in_ready`=0 is ignored; the source must hold it.

## Timing
- Accept takes one cycle (IDLE, `in_valid`=1).
- With the current multiplier, WAIT lasts 6 + popcount(`in_a`) cycles. This is 5 + popcount cycles with finish low plus 1 cycle with finish high.
- Per term from accept edge to accumulation edge: 9 + popcount(`in_a`) cycles; minimum 9, maximum 13.
- The sequencer relies only on `mul_finish`, never on a fixed count.
- `res_valid` rises the cycle after the last CAPT.
- After the `res_ready` handshake, `in_ready` rises the next cycle.
- There is no combinational path from `res_ready` or `in_valid` to any output.

## Configuration
- `DOT_PRODUCT_ZERO_SKIP_EN` defined:
  - In IDLE, an accepted pair with `in_a`==0 or `in_b`==0 bypasses the multiplier.
  - The counter increments and acc is unchanged, in the accept cycle itself.
  - Next state is DONE if it was the last term, otherwise IDLE, so `in_ready` stays 1.
  - `mul_reset` stays 1 and `mul_a`/`mul_b` are not updated.
- Undefined: every pair, including zero operands, goes through START/WAIT/CAPT with normal latency.

## Test plan
- Reset, then pairs (3,5),(2,7),(15,15),(1,1), `res_ready`=1 → `res_valid` with `res_data`=15+14+225+1=255, `res_ovf`=0; `mul_reset` pulses exactly once per term.
- Single pair (15,15): count cycles from accept to CAPT → 13. Pair (0,9) without the macro → 9, product 0.
- ACC_W=8, pairs (15,15)×2,(1,1),(0,1) → `res_data`=(225+225+1)&255=195, `res_ovf`=1. Next result after handshake → `res_ovf`=0.
- Hold `res_ready`=0 for 20 cycles in DONE while `in_valid`=1 → `res_data` stable, `in_ready`=0, no pair consumed. Release → `in_ready`=1 the following cycle.
- Assert `reset` during WAIT of the third term → next cycle IDLE, `mul_reset`=1, acc 0. The next four pairs produce a result free of old terms.
- With `DOT_PRODUCT_ZERO_SKIP_EN`, pairs (0,5),(4,0),(3,3),(0,0) → only one `mul_reset` pulse, `res_data`=9, `in_ready` stays high across the zero pairs.

Source files
------------

// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - operand sequencer and accumulator for a 4-bit serial-parallel multiplier
//
// Purpose:
//   Accepts 4-bit operand pairs, launches one multiplication per pair by
//   releasing the multiplier's reset, waits for its finish flag, adds each
//   8-bit product into an ACC_W-bit accumulator and, after N_TERMS products,
//   offers the sum on a valid/ready result port.
//
// Parameters:
//   N_TERMS  products per result (>= 1)
//   ACC_W    accumulator / result width (>= 8)
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   in_valid    operand pair offered
//   in_ready    sequencer can accept a pair (IDLE only)
//   in_a/in_b   4-bit operands, latched onto mul_a/mul_b on accept
//   res_valid   result available (DONE only)
//   res_ready   consumer takes result
//   res_data    accumulated sum (direct view of the accumulator)
//   res_ovf     sticky carry-out of the accumulator
//   mul_reset   multiplier reset; high except while a multiplication runs
//   mul_a/mul_b multiplier operands
//   mul_out     multiplier product
//   mul_finish  multiplier done flag
//
// Optional feature:
//   DOT_PRODUCT_ZERO_SKIP_EN  when defined, a pair with a zero operand is
//                             counted in the accept cycle without running
//                             the multiplier.

module dot_product_sequencer #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf,
  output logic             mul_reset,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_out,
  input  logic             mul_finish
);

  localparam int               CNT_W    = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;

  // One extra bit so the carry out of the accumulator is visible.
  logic [ACC_W:0]   sum_w;
  logic             last_term;

  assign sum_w     = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, mul_out};
  assign last_term = (cnt_q == LAST_CNT);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Next-state and output logic. Outputs decode the state only, so neither
  // in_valid nor res_ready reaches an output combinationally.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    mul_reset = 1'b1;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef DOT_PRODUCT_ZERO_SKIP_EN
          if ((in_a == 4'd0) || (in_b == 4'd0)) begin
            // Product is known to be zero: count the term, leave the
            // multiplier parked and its operands untouched.
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = last_term ? S_DONE : S_IDLE;
          end else begin
            a_d     = in_a;
            b_d     = in_b;
            state_d = S_START;
          end
`else
          a_d     = in_a;
          b_d     = in_b;
          state_d = S_START;
`endif
        end
      end

      S_START: begin
        // Single-cycle reset pulse also clears any finish flag left over
        // from the previous multiplication.
        state_d = S_WAIT;
      end

      S_WAIT: begin
        mul_reset = 1'b0;
        // The product is written on the edge that ends the finish cycle,
        // so it is picked up one state later in CAPT.
        if (mul_finish) begin
          state_d = S_CAPT;
        end
      end

      S_CAPT: begin
        mul_reset = 1'b0;
        acc_d     = sum_w[ACC_W-1:0];
        ovf_d     = ovf_q | sum_w[ACC_W];
        cnt_d     = cnt_q + CNT_W'(1);
        state_d   = last_term ? S_DONE : S_IDLE;
      end

      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign res_data = acc_q;
  assign res_ovf  = ovf_q;
  assign mul_a    = a_q;
  assign mul_b    = b_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb/tb_dot_product_sequencer.sv - self-checking bench for dot_product_sequencer
module tb_dot_product_sequencer;

  localparam int N_TERMS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid;
  logic       res_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;

  // Index 0: ACC_W=12 instance, index 1: ACC_W=8 instance; both see the
  // same stimulus so their control outputs must agree.
  logic [1:0]      in_ready;
  logic [1:0]      res_valid;
  logic [1:0]      res_ovf;
  logic [1:0]      m_rst;
  logic [1:0]      m_fin;
  logic [1:0]      m_done;
  logic [1:0][3:0] m_a;
  logic [1:0][3:0] m_b;
  logic [1:0][3:0] m_cnt;
  logic [1:0][7:0] m_out;
  logic [11:0]     res_data0;
  logic [7:0]      res_data1;

  int vectors     = 0;
  int miscompares = 0;
  int model_sum   = 0;
  int terms       = 0;
  int falls       = 0;
  logic prev_rst  = 1'b1;

  dot_product_sequencer #(.N_TERMS(N_TERMS), .ACC_W(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b), .res_valid(res_valid[0]), .res_ready(res_ready),
    .res_data(res_data0), .res_ovf(res_ovf[0]), .mul_reset(m_rst[0]),
    .mul_a(m_a[0]), .mul_b(m_b[0]), .mul_out(m_out[0]), .mul_finish(m_fin[0])
  );

  dot_product_sequencer #(.N_TERMS(N_TERMS), .ACC_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b), .res_valid(res_valid[1]), .res_ready(res_ready),
    .res_data(res_data1), .res_ovf(res_ovf[1]), .mul_reset(m_rst[1]),
    .mul_a(m_a[1]), .mul_b(m_b[1]), .mul_out(m_out[1]), .mul_finish(m_fin[1])
  );

  // Behavioural multiplier: after reset is released, finish stays low for
  // 5+popcount(A) cycles, is high for one cycle, and the product appears on
  // the edge that ends that cycle. Finish then stays high (stale) until reset.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_rst[k]) begin
        m_cnt[k]  <= 4'd0;
        m_fin[k]  <= 1'b0;
        m_done[k] <= 1'b0;
        m_out[k]  <= 8'd0;
      end else if (!m_fin[k]) begin
        m_cnt[k] <= m_cnt[k] + 4'd1;
        if (int'(m_cnt[k]) + 1 == 5 + $countones(m_a[k])) m_fin[k] <= 1'b1;
      end else if (!m_done[k]) begin
        m_out[k]  <= {4'd0, m_a[k]} * {4'd0, m_b[k]};
        m_done[k] <= 1'b1;
      end
    end
  end

  // Count multiplier launches (mul_reset falling).
  always @(posedge clk) begin
    if (prev_rst && !m_rst[0]) falls <= falls + 1;
    prev_rst <= m_rst[0];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Offers one pair, follows it to completion, and checks latency and the
  // running sum against the plain-arithmetic model.
  task automatic send_pair(input logic [3:0] a, input logic [3:0] b);
    int n;
    int lows;
    logic skip;
    logic last;
    logic [3:0] prev_a;
    n = 0;
    while (in_ready[0] !== 1'b1 && n < 50) begin tick(); n++; end
    vectors++;
    if (in_ready !== 2'b11) begin
      miscompares++; $display("FAIL accept_wait: in_ready=%b after %0d cycles, expected 11", in_ready, n);
    end
    skip = 1'b0;
`ifdef DOT_PRODUCT_ZERO_SKIP_EN
    skip = (a == 4'd0) || (b == 4'd0);
`endif
    prev_a   = m_a[0];
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
    model_sum += int'(a) * int'(b);
    terms++;
    last = (terms % N_TERMS) == 0;
    if (skip) begin
      vectors++;
      if (m_rst !== 2'b11 || m_a[0] !== prev_a) begin
        miscompares++; $display("FAIL skip_park: mul_reset=%b mul_a=%0d, expected 11 and %0d", m_rst, m_a[0], prev_a);
      end
    end else begin
      vectors++;
      if (m_a[0] !== a || m_b[0] !== b || m_rst !== 2'b11) begin
        miscompares++; $display("FAIL start_ops: a=%0d b=%0d rst=%b, expected %0d %0d 11", m_a[0], m_b[0], m_rst, a, b);
      end
      tick();
      lows = 0;
      while (m_rst[0] === 1'b0 && lows < 40) begin lows++; tick(); end
      vectors++;
      if (lows + 2 != 9 + $countones(a)) begin
        miscompares++; $display("FAIL term_latency: got %0d cycles, expected %0d (a=%0d)", lows + 2, 9 + $countones(a), a);
      end
    end
    vectors++;
    if (res_data0 !== 12'(model_sum) || res_data1 !== 8'(model_sum)) begin
      miscompares++; $display("FAIL partial_sum: got %0d/%0d, expected %0d/%0d", res_data0, res_data1, 12'(model_sum), 8'(model_sum));
    end
    vectors++;
    if (res_valid !== {2{last}} || in_ready !== {2{!last}}) begin
      miscompares++; $display("FAIL term_end_flags: res_valid=%b in_ready=%b, expected %b %b", res_valid, in_ready, {2{last}}, {2{!last}});
    end
  endtask

  // Checks the presented result, holds it for `hold` cycles, then handshakes.
  task automatic get_result(input int hold);
    int n;
    logic [11:0] e12;
    logic [7:0]  e8;
    logic [1:0]  eovf;
    n = 0;
    while (res_valid[0] !== 1'b1 && n < 50) begin tick(); n++; end
    e12  = 12'(model_sum);
    e8   = 8'(model_sum);
    eovf = {model_sum >= 256, model_sum >= 4096};
    vectors++;
    if (res_valid !== 2'b11 || res_data0 !== e12 || res_data1 !== e8 || res_ovf !== eovf) begin
      miscompares++;
      $display("FAIL result: valid=%b data=%0d/%0d ovf=%b, expected 11 %0d/%0d %b", res_valid, res_data0, res_data1, res_ovf, e12, e8, eovf);
    end
    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      vectors++;
      if (res_valid !== 2'b11 || in_ready !== 2'b00 || res_data0 !== e12 || res_ovf !== eovf) begin
        miscompares++; $display("FAIL result_hold: cycle %0d valid=%b ready=%b data=%0d, expected 11 00 %0d", i, res_valid, in_ready, res_data0, e12);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vectors++;
    if (res_valid !== 2'b00 || in_ready !== 2'b11 || res_data0 !== 12'd0 || res_data1 !== 8'd0 || res_ovf !== 2'b00) begin
      miscompares++; $display("FAIL after_handshake: valid=%b ready=%b data=%0d ovf=%b, expected 00 11 0 00", res_valid, in_ready, res_data0, res_ovf);
    end
    model_sum = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_a = 4'hF; in_b = 4'hF; res_ready = 1'b0;
    repeat (3) tick();
    vectors++;
    if (in_ready !== 2'b11 || res_valid !== 2'b00 || res_ovf !== 2'b00 || m_rst !== 2'b11) begin
      miscompares++; $display("FAIL reset_flags: ready=%b valid=%b ovf=%b mrst=%b, expected 11 00 00 11", in_ready, res_valid, res_ovf, m_rst);
    end
    vectors++;
    if (res_data0 !== 12'd0 || res_data1 !== 8'd0 || m_a !== 8'd0 || m_b !== 8'd0) begin
      miscompares++; $display("FAIL reset_data: data=%0d/%0d mul_a=%h mul_b=%h, expected 0", res_data0, res_data1, m_a, m_b);
    end
    reset = 1'b0; in_valid = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 2'b11 || m_rst !== 2'b11) begin
      miscompares++; $display("FAIL idle_after_reset: ready=%b mrst=%b, expected 11 11", in_ready, m_rst);
    end
    model_sum = 0; terms = 0;
  endtask

  task automatic test_basic();
    int f0;
    f0 = falls;
    send_pair(4'd3, 4'd5);
    send_pair(4'd2, 4'd7);
    send_pair(4'd15, 4'd15);
    send_pair(4'd1, 4'd1);
    vectors++;
    if (falls - f0 != 4) begin
      miscompares++; $display("FAIL basic_launches: got %0d, expected 4", falls - f0);
    end
    vectors++;
    if (res_data0 !== 12'd255) begin
      miscompares++; $display("FAIL basic_sum: got %0d, expected 255", res_data0);
    end
    get_result(0);
  endtask

  task automatic test_latency();
    send_pair(4'd15, 4'd15);
    send_pair(4'd9, 4'd0);
    send_pair(4'd0, 4'd9);
    send_pair(4'd8, 4'd2);
    get_result(1);
  endtask

  task automatic test_overflow();
    send_pair(4'd15, 4'd15);
    send_pair(4'd15, 4'd15);
    send_pair(4'd1, 4'd1);
    send_pair(4'd0, 4'd1);
    vectors++;
    if (res_data1 !== 8'd195 || res_ovf !== 2'b10 || res_data0 !== 12'd451) begin
      miscompares++; $display("FAIL overflow: data8=%0d ovf=%b data12=%0d, expected 195 10 451", res_data1, res_ovf, res_data0);
    end
    get_result(2);
    for (int i = 0; i < 4; i++) send_pair(4'd1, 4'd1);
    get_result(0);
  endtask

  task automatic test_backpressure();
    int f0;
    logic [3:0] a0;
    send_pair(4'd7, 4'd9);
    send_pair(4'd4, 4'd11);
    send_pair(4'd6, 4'd13);
    send_pair(4'd5, 4'd5);
    f0 = falls;
    a0 = m_a[0];
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (in_ready !== 2'b00 || res_valid !== 2'b11 || res_data0 !== 12'(model_sum) || m_a[0] !== a0) begin
        miscompares++; $display("FAIL bp_hold: cycle %0d ready=%b valid=%b data=%0d mul_a=%0d, expected 00 11 %0d %0d", i, in_ready, res_valid, res_data0, m_a[0], 12'(model_sum), a0);
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (falls != f0) begin
      miscompares++; $display("FAIL bp_no_launch: got %0d launches, expected 0", falls - f0);
    end
    get_result(0);
  endtask

  task automatic test_mid_reset();
    int n;
    send_pair(4'd12, 4'd12);
    send_pair(4'd10, 4'd3);
    n = 0;
    while (in_ready[0] !== 1'b1 && n < 50) begin tick(); n++; end
    in_valid = 1'b1; in_a = 4'd7; in_b = 4'd3;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    vectors++;
    if (m_rst !== 2'b00) begin
      miscompares++; $display("FAIL mid_in_wait: mul_reset=%b, expected 00", m_rst);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (in_ready !== 2'b11 || m_rst !== 2'b11 || res_data0 !== 12'd0 || res_valid !== 2'b00 || m_a[0] !== 4'd0) begin
      miscompares++; $display("FAIL mid_reset: ready=%b mrst=%b data=%0d valid=%b mul_a=%0d, expected 11 11 0 00 0", in_ready, m_rst, res_data0, res_valid, m_a[0]);
    end
    model_sum = 0; terms = 0;
    for (int i = 0; i < 4; i++) send_pair(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)));
    get_result(0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) send_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      get_result(int'($urandom_range(0, 5)));
    end
  endtask

  task automatic test_zero_operands();
    int f0;
    int exp_launch;
    f0 = falls;
    send_pair(4'd0, 4'd5);
    send_pair(4'd4, 4'd0);
    send_pair(4'd3, 4'd3);
    send_pair(4'd0, 4'd0);
`ifdef DOT_PRODUCT_ZERO_SKIP_EN
    exp_launch = 1;
`else
    exp_launch = 4;
`endif
    vectors++;
    if (falls - f0 != exp_launch || res_data0 !== 12'd9) begin
      miscompares++; $display("FAIL zero_operands: launches=%0d data=%0d, expected %0d 9", falls - f0, res_data0, exp_launch);
    end
    get_result(0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0; res_ready = 1'b0;
    test_reset();
    test_basic();
    test_latency();
    test_overflow();
    test_backpressure();
    test_mid_reset();
    test_zero_operands();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
